// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: default width and
// capture FSM state encoding.
package pwm_pkg;

  localparam int PWM_WIDTH       = 10;
  localparam int PWM_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    STALLED = 2'd3
  } pwm_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Result bus of pwm_capture: one period/high-time measurement per PWM cycle.
// o_valid is a one-cycle strobe with no ready: the consumer cannot stall and
// must take o_period/o_high (and o_timeout) in the cycle o_valid is high.
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
);

  logic [WIDTH-1:0] o_period;
  logic [WIDTH-1:0] o_high;
  logic             o_valid;
  logic             o_timeout;
  logic             o_cycle_start;

  modport master (
    output o_period,
    output o_high,
    output o_valid,
    output o_timeout,
    output o_cycle_start
  );

  modport slave (
    input o_period,
    input o_high,
    input o_valid,
    input o_timeout,
    input o_cycle_start
  );

endinterface

// File: rtl/input_sync.sv
// Multi-flop synchronizer for an asynchronous PWM pin, plus a one-cycle delayed
// copy used to detect rising edges of the synchronized level.
module input_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_pwm,
  output logic o_s,
  output logic o_rise
);

  logic [STAGES-1:0] sync_q;
  logic              s_prev;

  // Left unreset so a reset while the pin is high cannot fabricate a rising edge.
  always_ff @(posedge i_clk) begin
    sync_q <= {sync_q[STAGES-2:0], i_pwm};
    s_prev <= sync_q[STAGES-1];
  end

  assign o_s    = sync_q[STAGES-1];
  assign o_rise = o_s & ~s_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM signal in clock cycles,
// reporting one result per PWM cycle and flagging a stuck input.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pwm,
  pwm_capture_if.master res,
  output pwm_state_t    o_state
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic             s;
  logic             rise;
  logic             timeout_hit;
  pwm_state_t       state;
  logic [WIDTH-1:0] p_cnt;
  logic [WIDTH-1:0] h_cnt;

  input_sync #(
    .STAGES (SYNC_STAGES)
  ) u_input_sync (
    .i_clk  (i_clk),
    .i_pwm  (i_pwm),
    .o_s    (s),
    .o_rise (rise)
  );

  // A rise in the same cycle as saturation is a valid edge, not a timeout.
  assign timeout_hit = (state != STALLED) && (p_cnt == MAX) && !rise;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      p_cnt             <= '0;
      h_cnt             <= '0;
      res.o_period      <= '0;
      res.o_high        <= '0;
      res.o_valid       <= 1'b0;
      res.o_timeout     <= 1'b0;
      res.o_cycle_start <= 1'b0;
    end else begin
      res.o_valid       <= 1'b0;
      res.o_cycle_start <= rise;

      if (rise) begin
        p_cnt <= WIDTH'(1);
        h_cnt <= WIDTH'(1);
      end else begin
        if (p_cnt != MAX) p_cnt <= p_cnt + 1'b1;
        if (s && (h_cnt != MAX)) h_cnt <= h_cnt + 1'b1;
      end

      if (timeout_hit) begin
        state         <= STALLED;
        res.o_period  <= MAX;
        res.o_high    <= s ? MAX : '0;
        res.o_valid   <= 1'b1;
        res.o_timeout <= 1'b1;
      end else begin
        case (state)
          // Wait out any high phase already in progress at reset.
          IDLE: begin
            if (!s) begin
              state <= ARMED;
              p_cnt <= '0;
              h_cnt <= '0;
            end
          end
          ARMED: begin
            if (rise) state <= MEASURE;
          end
          MEASURE: begin
            if (rise) begin
              res.o_period <= p_cnt;
              res.o_high   <= h_cnt;
              res.o_valid  <= 1'b1;
            end
          end
          STALLED: begin
            if (rise) begin
              state         <= MEASURE;
              res.o_timeout <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives synthetic PWM waveforms and checks the
// reported period/high/timeout results against hand-computed values.
module tb_pwm_capture;
  import pwm_pkg::*;

  localparam int W  = 10;
  localparam int RW = 2 * W + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwm;
  pwm_state_t st;

  pwm_capture_if #(.WIDTH(W)) cap ();

  pwm_capture #(
    .WIDTH       (W),
    .SYNC_STAGES (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_pwm   (pwm),
    .res     (cap),
    .o_state (st)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];  // {timeout, period, high}
  logic [RW-1:0] rec_q[$];
  int            vcyc_q[$];
  int            cs_q[$];
  int            cyc = 0;
  int            n_asserts = 0;
  int            n_fail = 0;

  // Monitor samples outputs well after the active edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (cap.o_valid) begin
      rec_q.push_back({cap.o_timeout, cap.o_period, cap.o_high});
      vcyc_q.push_back(cyc);
    end
    if (cap.o_cycle_start) cs_q.push_back(cyc);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v);
    @(negedge clk);
    pwm = v;
  endtask

  task automatic pwm_cycles(input int p, input int h, input int n);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++)
        step(i < h);
  endtask

  // One extra rising edge so the last full period gets reported.
  task automatic tail();
    step(1'b1);
    repeat (3) step(1'b0);
  endtask

  task automatic do_reset(input logic v);
    rst_n = 1'b0;
    repeat (4) step(v);
    rst_n = 1'b1;
    rec_q.delete();
    vcyc_q.delete();
    cs_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_res(input logic t, input int p, input int h, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({t, W'(p), W'(h)});
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, " count"}, 32'(rec_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rec_q.size() > 0)
      check(tag, 32'(rec_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    rec_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit gaps_ok;

    rst_n = 1'b0;
    pwm   = 1'b0;
    repeat (4) step(1'b0);
    check("reset period", 32'(cap.o_period), 32'd0);
    check("reset high", 32'(cap.o_high), 32'd0);
    check("reset valid", 32'(cap.o_valid), 32'd0);
    check("reset timeout", 32'(cap.o_timeout), 32'd0);
    check("reset cycle_start", 32'(cap.o_cycle_start), 32'd0);
    check("reset state", 32'(st), 32'(IDLE));

    // Period 256, high 100 from reset
    do_reset(1'b0);
    pwm_cycles(256, 100, 4);
    tail();
    check("p256 first valid latency", 32'(vcyc_q[0] - cs_q[0]), 32'd256);
    gaps_ok = (vcyc_q.size() == 4);
    for (int i = 1; i < vcyc_q.size(); i++)
      if (vcyc_q[i] - vcyc_q[i-1] != 256) gaps_ok = 1'b0;
    check("p256 valid spacing", 32'(gaps_ok), 32'd1);
    expect_res(1'b0, 256, 100, 4);
    check_results("p256 h100");

    // Loopback-style waveform, compare change 128 -> 32 at a period boundary
    do_reset(1'b0);
    pwm_cycles(256, 128, 3);
    pwm_cycles(256, 32, 3);
    tail();
    expect_res(1'b0, 256, 128, 3);
    expect_res(1'b0, 256, 32, 3);
    check_results("loopback");

    // Minimum period
    do_reset(1'b0);
    pwm_cycles(2, 1, 10);
    tail();
    check("p2 cycle_start count", 32'(cs_q.size()), 32'd11);
    gaps_ok = 1'b1;
    for (int i = 1; i < cs_q.size(); i++)
      if (cs_q[i] - cs_q[i-1] != 2) gaps_ok = 1'b0;
    check("p2 cycle_start every other", 32'(gaps_ok), 32'd1);
    expect_res(1'b0, 2, 1, 10);
    check_results("p2 h1");

    // Stuck high, then resume
    do_reset(1'b0);
    pwm_cycles(100, 40, 2);
    repeat (1100) step(1'b1);
    check("stuck high timeout", 32'(cap.o_timeout), 32'd1);
    check("stuck high state", 32'(st), 32'(STALLED));
    expect_res(1'b0, 100, 40, 2);
    expect_res(1'b1, 1023, 1023, 1);
    check_results("stuck high");
    pwm_cycles(100, 40, 1);
    check("stalled holds timeout", 32'(cap.o_timeout), 32'd1);
    check_results("stalled no valid");
    pwm_cycles(100, 40, 2);
    tail();
    check("resume timeout cleared", 32'(cap.o_timeout), 32'd0);
    expect_res(1'b0, 100, 40, 2);
    check_results("resume");

    // Stuck low
    do_reset(1'b0);
    pwm_cycles(100, 40, 2);
    repeat (1100) step(1'b0);
    check("stuck low timeout", 32'(cap.o_timeout), 32'd1);
    expect_res(1'b0, 100, 40, 1);
    expect_res(1'b1, 1023, 0, 1);
    check_results("stuck low");

    // Reset during high phase with input held high
    do_reset(1'b0);
    pwm_cycles(100, 40, 1);
    repeat (10) step(1'b1);
    do_reset(1'b1);
    repeat (20) step(1'b1);
    check("held high no cycle_start", 32'(cs_q.size()), 32'd0);
    check("held high state", 32'(st), 32'(IDLE));
    repeat (60) step(1'b0);
    check("after low state", 32'(st), 32'(ARMED));
    pwm_cycles(100, 40, 2);
    tail();
    expect_res(1'b0, 100, 40, 2);
    check_results("reset in high");

    // Period equal to MAX: rise wins over timeout
    do_reset(1'b0);
    pwm_cycles(1023, 500, 2);
    tail();
    check("p1023 no timeout", 32'(cap.o_timeout), 32'd0);
    expect_res(1'b0, 1023, 500, 2);
    check_results("p1023");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its period and high time in clock cycles, one result per PWM cycle. It is the receive-side counterpart of the `pwm` generator: it sits behind a PMOD input pin and recovers `top`/`compare`-style values. Uses include loopback checking of the audio PWM path and reading external PWM sources. A timeout detects stuck-high or stuck-low inputs.

## Interface
- `WIDTH`, 10: counter and result width; saturates at 2^WIDTH-1.
- `SYNC_STAGES`, 2: synchronizer flops on `i_pwm`; minimum 2.

- `i_clk`  in  1: system clock.
- `i_rst_n`  in  1: reset, synchronous, active-low.
- `i_pwm`  in  1: asynchronous PWM input.
- `o_period`  out  WIDTH: cycles between successive rising edges; reset 0.
- `o_high`  out  WIDTH: high cycles within that period; reset 0.
- `o_valid`  out  1: single-cycle strobe when `o_period`/`o_high` update; reset 0.
- `o_timeout`  out  1: level, input stuck; reset 0.
- `o_cycle_start`  out  1: single-cycle strobe on every detected rising edge; reset 0.

## Operation
- `i_pwm` passes through `SYNC_STAGES` flops, giving `s`. `s_prev` is `s` delayed one cycle. `rise = s & ~s_prev`.
- **Counters**
  - `p_cnt` and `h_cnt` are both WIDTH bits and saturate at MAX = 2^WIDTH-1.
  - On `rise`: `p_cnt` <= 1; `h_cnt` <= 1.
  - Otherwise: `p_cnt` increments every cycle. `h_cnt` increments when `s` = 1.
- **States**
  - IDLE: wait for `s` = 0. Go to ARMED. This discards a partial high phase after reset.
  - ARMED: on `rise`, go to MEASURE and load the counters. No `o_valid`.
  - MEASURE: on `rise`, register `o_period` <= `p_cnt` and `o_high` <= `h_cnt`, pulse `o_valid`, reload the counters, and stay in MEASURE.
  - STALLED: `o_timeout` = 1. On `rise`, clear `o_timeout`, load the counters, and go to MEASURE. No `o_valid` on this edge.
- **Timeout**
  - Applies in every state except STALLED.
  - If `p_cnt` = MAX and there is no `rise` that cycle: go to STALLED, set `o_period` <= MAX, set `o_high` <= (`s` ? MAX : 0), pulse `o_valid` once.
  - In IDLE and ARMED, `p_cnt` counts from reset or from state entry.
- `o_cycle_start` pulses on every `rise` in every state.
- **Simultaneous events:** `rise` takes priority over timeout in the same cycle.
- **Reset:** a reset asserted mid-measurement discards all counts. All outputs return to 0 and the state returns to IDLE on the next edge.

## Timing
- Rise detection happens (`SYNC_STAGES`+1) clock edges after the first edge that samples `i_pwm` high. `o_valid` and `o_cycle_start` are high in the following cycle, i.e. registered at that edge.
- Results are exact for a stable input with period P ≥ 2 and high time 1 ≤ H ≤ P-1: `o_period` = P, `o_high` = H.
- The first `o_valid` after reset arrives one full period after the first rise seen in ARMED.
- Input pulses shorter than one clock may be missed. This is not an error condition.
- All outputs are registered. There are no combinational paths from inputs.

## Structure
- Shared package `pwm_pkg`: state encoding (IDLE/ARMED/MEASURE/STALLED, 2 bits) and the default width constant, shared with `pwm`.
- Sub-module `input_sync`: parameterised synchronizer plus `s_prev` register. Outputs are `s` and `rise`.
- `pwm_capture` holds the FSM, counters and output registers.

## Test plan
- **Period 256, high 100, from reset:** first `o_valid` after one full period, then exactly one `o_valid` every 256 cycles with `o_period`=256 and `o_high`=100.
- **Loopback from `pwm` (top 8'hff, compare 128):** `o_period`=256, `o_high`=128. Change compare to 32: the first result for the new waveform reads `o_high`=32, with at most one intermediate (mixed) result.
- **Minimum period:** P=2, H=1 gives `o_period`=2 and `o_high`=1 on every `o_valid`. `o_cycle_start` is high every other cycle.
- **Stuck high with WIDTH=10:** after the last rise, one `o_valid` with `o_period`=1023, `o_high`=1023 and `o_timeout`=1. No further `o_valid`. Resuming P=100, H=40: `o_timeout` clears at the rise, and the next `o_valid` gives 100/40.
- **Stuck low:** gives `o_high`=0 and `o_timeout`=1.
- **Reset during high phase, input held high:** no `o_cycle_start` until `s` goes low and then rises. The first `o_valid` reports the correct P/H.
- **Rise coinciding with `p_cnt`=MAX (P=1023):** produces a normal result with `o_period`=1023 and `o_timeout` stays 0.
